// File: rtl/multicycle_core_if.sv
// Memory bus between the multicycle core and its single shared memory.
// The core holds mem_req (and the address/data alongside it) until mem_ack.
interface multicycle_core_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle MIPS-subset core: FETCH -> DECODE -> EXEC -> (MEM) -> (WB).
// One shared memory port for instructions and data, 32 x 32 register file,
// and a retired-instruction counter. HALT is sticky until reset.
module multicycle_core #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [4:0]  LED_REG  = 5'd2,
   parameter int          CNT_W    = 32
) (
   input  logic             clk,
   input  logic             reset,
   multicycle_core_if.master mem,
   output logic [31:0]      pc,
   output logic             halted,
   output logic [1:0]       fault,
   output logic [CNT_W-1:0] retired,
   output logic [7:0]       leds
);

   typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_SLT   = 6'h2A;

   state_t      state, state_nx;
   logic [31:0] ir;
   logic [31:0] a_q, b_q, imm_q;
   logic [31:0] res_q;          // ALU result, JAL link, or loaded data
   logic [1:0]  fault_q;
   logic [31:0] regs [32];

   // instruction fields
   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [25:0] imm26;
   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];
   assign imm16 = ir[15:0];
   assign imm26 = ir[25:0];

   logic        is_sw;
   logic [4:0]  wb_dst;
   assign is_sw  = (op == OP_SW);
   assign wb_dst = (op == OP_RTYPE) ? rd : (op == OP_JAL) ? 5'd31 : rt;

   // bus drive
   logic        req, we, ack;
   logic [31:0] addr;
   logic        retire;
   assign mem.mem_req   = req;
   assign mem.mem_we    = we;
   assign mem.mem_addr  = addr;
   assign mem.mem_wdata = b_q;
   assign ack           = mem.mem_ack & req;

   assign halted  = (state == HALT);
   assign fault   = fault_q;
   assign leds    = regs[LED_REG][7:0];

   // EXEC datapath: ALU result, control-flow target and next state
   logic [31:0]        alu_r, ex_pc_val;
   logic               ex_pc_ld;
   logic [1:0]         ex_fault;
   state_t             ex_nx;
   logic signed [31:0] sa, sb;
   always_comb begin
      alu_r     = '0;
      ex_pc_ld  = 1'b0;
      ex_pc_val = pc;
      ex_fault  = 2'd0;
      ex_nx     = WB;
      sa        = a_q;
      sb        = b_q;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: alu_r = a_q + b_q;
               FN_SUBU: alu_r = a_q - b_q;
               FN_AND:  alu_r = a_q & b_q;
               FN_OR:   alu_r = a_q | b_q;
               FN_SLT:  alu_r = {31'd0, (sa < sb)};
               FN_SLL:  alu_r = b_q << shamt;
               FN_SRL:  alu_r = b_q >> shamt;
               FN_JR: begin
                  ex_pc_ld  = 1'b1;
                  ex_pc_val = a_q;
                  ex_nx     = FETCH;
               end
               default: begin
                  ex_nx    = HALT;
                  ex_fault = 2'd1;
               end
            endcase
         end
         OP_J: begin
            ex_pc_ld  = 1'b1;
            ex_pc_val = {pc[31:28], imm26, 2'b00};
            ex_nx     = FETCH;
         end
         OP_JAL: begin
            alu_r     = pc;     // pc already points past the JAL
            ex_pc_ld  = 1'b1;
            ex_pc_val = {pc[31:28], imm26, 2'b00};
         end
         OP_BEQ, OP_BNE: begin
            ex_pc_ld  = ((a_q == b_q) == (op == OP_BEQ));
            ex_pc_val = pc + {imm_q[29:0], 2'b00};
            ex_nx     = FETCH;
         end
         OP_ADDIU: alu_r = a_q + imm_q;
         OP_ANDI:  alu_r = a_q & imm_q;
         OP_ORI:   alu_r = a_q | imm_q;
         OP_LUI:   alu_r = {imm16, 16'h0000};
         OP_LW, OP_SW: begin
            alu_r = a_q + imm_q;
            if (alu_r[1:0] != 2'b00) begin
               ex_nx    = HALT;
               ex_fault = 2'd2;
            end else begin
               ex_nx = MEM;
            end
         end
         default: begin
            ex_nx    = HALT;
            ex_fault = 2'd1;
         end
      endcase
   end

   // FSM next state, bus request and retire strobe
   always_comb begin
      state_nx = state;
      req      = 1'b0;
      we       = 1'b0;
      addr     = pc;
      retire   = 1'b0;
      case (state)
         FETCH: begin
            req = reset;   // bus goes idle the instant reset asserts
            if (mem.mem_ack && reset) state_nx = DECODE;
         end
         DECODE: state_nx = EXEC;
         EXEC: begin
            state_nx = ex_nx;
            retire   = (ex_nx == FETCH);
         end
         MEM: begin
            req  = reset;
            we   = is_sw;
            addr = res_q;
            if (mem.mem_ack && reset) begin
               state_nx = is_sw ? FETCH : WB;
               retire   = is_sw;
            end
         end
         WB: begin
            state_nx = FETCH;
            retire   = 1'b1;
         end
         HALT:    state_nx = HALT;
         default: state_nx = HALT;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_nx;
   end

   // datapath and architectural state updates per FSM state
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         fault_q <= 2'd0;
         retired <= '0;
         for (int i = 0; i < 32; i++) regs[i] <= '0;
      end else begin
         retired <= retired + CNT_W'(retire);
         case (state)
            FETCH: begin
               if (ack) begin
                  ir <= mem.mem_rdata;
                  pc <= pc + 32'd4;
               end
            end
            DECODE: begin
               a_q   <= regs[rs];
               b_q   <= regs[rt];
               imm_q <= (op == OP_ANDI || op == OP_ORI) ? {16'h0000, imm16}
                                                        : {{16{imm16[15]}}, imm16};
            end
            EXEC: begin
               res_q <= alu_r;
               if (ex_pc_ld) pc <= ex_pc_val;
               if (ex_nx == HALT) fault_q <= ex_fault;
            end
            MEM: begin
               if (ack && !is_sw) res_q <= mem.mem_rdata;
            end
            WB: begin
               if (wb_dst != 5'd0) regs[wb_dst] <= res_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/multicycle_core.md
MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-002 Parameter LED_REG, default 5'd2, SHALL select the register whose bits [7:0] drive leds.
REQ-003 Parameter CNT_W, default 32, SHALL set the retired-instruction counter width.
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 reset  in  1  SHALL be the asynchronous, active-low reset (0 = reset).
REQ-006 mem_req  out  1  SHALL be the memory request, held until acknowledged.
REQ-007 mem_we  out  1  SHALL mark the request as a write (SW only).
REQ-008 mem_addr  out  32  SHALL be the byte address, stable while mem_req=1.
REQ-009 mem_wdata  out  32  SHALL be the store data, stable while mem_req=1.
REQ-010 mem_rdata  in  32  SHALL be the read data, valid in the mem_ack cycle.
REQ-011 mem_ack  in  1  SHALL complete the pending request in the cycle it is 1 with mem_req=1.
REQ-012 pc  out  32  SHALL be the current PC register.
REQ-013 halted  out  1  SHALL be 1 in the HALT state.
REQ-014 fault  out  2  SHALL give the halt cause: 0 none, 1 illegal opcode/funct, 2 misaligned data address.
REQ-015 retired  out  CNT_W  SHALL count completed instructions.
REQ-016 leds  out  8  SHALL equal register LED_REG bits [7:0].

Function
REQ-017 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB, HALT.
REQ-018 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on ack, latch IR=mem_rdata, pc<=pc+4, go to DECODE; without ack, stay in FETCH.
REQ-019 DECODE SHALL latch A=R[rs], B=R[rt], the immediate (sign- or zero-extended per opcode) and a 32-entry register file, then go to EXEC, taking exactly 1 cycle.
REQ-020 EXEC SHALL compute ADDU, SUBU, AND, OR, SLT (signed), SLL, SRL (shamt), ADDIU, ANDI/ORI (zero-extended), LUI (imm<<16), and LW/SW address A+sext(imm).
REQ-021 EXEC branches: BEQ/BNE SHALL set pc<=pc+(sext(imm)<<2) when taken, then go to FETCH.
REQ-022 EXEC jumps: J SHALL set pc<={pc[31:28],imm26,2'b00}; JR SHALL set pc<=A; both SHALL go to FETCH.
REQ-023 EXEC JAL SHALL latch link=pc, perform the J target update, then go to WB.
REQ-024 EXEC LW/SW SHALL go to MEM, or to HALT with fault=2 when addr[1:0]!=0.
REQ-025 EXEC on an unsupported opcode or funct SHALL go to HALT with fault=1.
REQ-026 ALU ops and LUI SHALL go from EXEC to WB.
REQ-027 MEM: mem_req=1, mem_addr=ALU result, mem_we=1 for SW with mem_wdata=B; on ack, LW SHALL go to WB with data latched, SW SHALL go to FETCH.
REQ-028 WB SHALL write the destination register, then go to FETCH: rd for R-type, rt for I-type/LW, 31 for JAL.
REQ-029 Register 0 SHALL read 0 always; writes to it SHALL be discarded.
REQ-030 retired SHALL increment by 1 on leaving EXEC to FETCH, on leaving MEM to FETCH and on leaving WB, and SHALL wrap modulo 2^CNT_W.
REQ-031 Cycle cost with zero-wait ack SHALL be: branch/jump/JR 3, ALU/JAL 4, SW 4, LW 5; each ack wait cycle SHALL add 1.
REQ-032 mem_ack while mem_req=0 SHALL be ignored.
REQ-033 HALT SHALL be terminal until reset: mem_req=0 and no register or PC change.
REQ-034 Arithmetic SHALL be modulo 2^32; overflow SHALL not trap.

Reset
REQ-035 While reset=0: state=FETCH, pc=RESET_PC, mem_req=0, mem_we=0, halted=0, fault=0, retired=0, and all registers=0.
REQ-036 Reset asserted mid-transaction SHALL abort it immediately, and the first request after release SHALL be a fetch at RESET_PC.

Verification
REQ-037 ORI $2,$0,0x5A with zero-wait memory -> leds=8'h5A, retired=1 at the 4th cycle edge, pc=RESET_PC+4.
REQ-038 LW $3,0($0) with ack delayed 3 cycles, mem_rdata=0xDEADBEEF -> R3=0xDEADBEEF, the LW taking 5+3 cycles.
REQ-039 BEQ $0,$0,-1 -> pc returns to the same address every 3 cycles, and retired increments each loop.
REQ-040 JAL at 0x100 -> R31=0x104, pc equals the jump target.
REQ-041 SW with address 0x2 -> halted=1, fault=2, no write request issued; opcode 6'h3F -> fault=1.
REQ-042 reset=0 during MEM wait -> mem_req drops in the same cycle; after release, the first mem_addr=RESET_PC.
